// File: rtl/mem_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter: core port, loader port,
// memory command/return port and the status block.
// The arbiter uses the slave view; whoever drives the requesters and models
// the memory uses the master view.
interface mem_arbiter_if;
  // Core requester
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic        c_rvalid;
  logic [31:0] c_rdata;

  // Loader requester
  logic        l_req;
  logic        l_we;
  logic        l_lock;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;

  // Memory side
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  // Status
  logic        stat_clr;
  logic [31:0] status;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  l_req, l_we, l_lock, l_addr, l_wdata,
    input  m_ready, m_rdata, stat_clr,
    output c_gnt, c_rvalid, c_rdata,
    output l_gnt, l_rvalid, l_rdata,
    output m_en, m_we, m_addr, m_wdata,
    output status
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output l_req, l_we, l_lock, l_addr, l_wdata,
    output m_ready, m_rdata, stat_clr,
    input  c_gnt, c_rvalid, c_rdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    input  status
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (core / loader).
// Round-robin selection on the last granted requester, a loader lock that
// excludes the core for a bounded number of cycles, one-cycle read return
// routing, and a core-wait / lock-timeout status word.
module mem_arbiter #(
  parameter int LOCK_MAX = 64
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e   r_state;
  logic          r_last_l;      // 1: loader was granted most recently
  logic [CW-1:0] r_lock_cnt;
  logic          r_relock_blk;  // set by a forced unlock until the loader lets go
  logic          r_rpend;
  logic          r_rsel;        // 1: pending read belongs to the loader
  logic [15:0]   r_wait;
  logic          r_timeout;

  logic w_sel_c;
  logic w_sel_l;
  logic w_c_gnt;
  logic w_l_gnt;
  logic w_timeout;
  logic w_unlock;

  // Pick the candidate requester from lock state and round-robin history.
  always_comb begin
    w_sel_c = 1'b0;
    w_sel_l = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_sel_l = bus.l_req;
    end else if (bus.c_req && bus.l_req) begin
      w_sel_c = r_last_l;
      w_sel_l = ~r_last_l;
    end else begin
      w_sel_c = bus.c_req;
      w_sel_l = bus.l_req;
    end
  end

  // Grants need memory readiness and are suppressed while reset is held.
  always_comb begin
    w_c_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (rst && bus.m_ready) begin
      w_c_gnt = w_sel_c;
      w_l_gnt = w_sel_l;
    end else begin
      w_c_gnt = 1'b0;
      w_l_gnt = 1'b0;
    end
  end

  assign w_timeout = (r_state == ST_LOCKED) && (r_lock_cnt == LOCK_LAST);
  assign w_unlock  = (w_l_gnt && !bus.l_lock) || (!bus.l_req && !bus.l_lock);

  assign bus.c_gnt   = w_c_gnt;
  assign bus.l_gnt   = w_l_gnt;
  assign bus.m_en    = w_c_gnt | w_l_gnt;
  assign bus.m_we    = w_l_gnt ? bus.l_we    : bus.c_we;
  assign bus.m_addr  = w_l_gnt ? bus.l_addr  : bus.c_addr;
  assign bus.m_wdata = w_l_gnt ? bus.l_wdata : bus.c_wdata;

  assign bus.c_rvalid = r_rpend & ~r_rsel;
  assign bus.l_rvalid = r_rpend &  r_rsel;
  assign bus.c_rdata  = bus.m_rdata;
  assign bus.l_rdata  = bus.m_rdata;

  assign bus.status = {r_timeout, (r_state == ST_LOCKED), 14'b0, r_wait};

  // Lock FSM with its cycle counter, round-robin history and relock guard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_l     <= 1'b1;
      r_lock_cnt   <= '0;
      r_relock_blk <= 1'b0;
    end else begin
      if (w_c_gnt) begin
        r_last_l <= 1'b0;
      end else if (w_l_gnt) begin
        r_last_l <= 1'b1;
      end else begin
        r_last_l <= r_last_l;
      end
      case (r_state)
        ST_IDLE: begin
          r_lock_cnt <= '0;
          if (w_l_gnt && bus.l_lock && !r_relock_blk) begin
            r_state <= ST_LOCKED;
          end else begin
            r_state <= ST_IDLE;
          end
          if (r_relock_blk && ((w_l_gnt && !bus.l_lock) || !bus.l_req)) begin
            r_relock_blk <= 1'b0;
          end else begin
            r_relock_blk <= r_relock_blk;
          end
        end
        ST_LOCKED: begin
          if (w_timeout) begin
            // Forced release: hand the next contention to the core.
            r_state      <= ST_IDLE;
            r_lock_cnt   <= '0;
            r_last_l     <= 1'b1;
            r_relock_blk <= 1'b1;
          end else if (w_unlock) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
          end else begin
            r_state    <= ST_LOCKED;
            r_lock_cnt <= r_lock_cnt + CW'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end

  // Remember who owns the read issued this cycle so its data is routed next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rpend <= 1'b0;
      r_rsel  <= 1'b0;
    end else begin
      r_rpend <= (w_c_gnt & ~bus.c_we) | (w_l_gnt & ~bus.l_we);
      r_rsel  <= w_l_gnt;
    end
  end

  // Core-wait counter and sticky lock-timeout flag; a clear beats any update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait    <= 16'h0000;
      r_timeout <= 1'b0;
    end else if (bus.stat_clr) begin
      r_wait    <= 16'h0000;
      r_timeout <= 1'b0;
    end else begin
      if (bus.c_req && !w_c_gnt && (r_wait != 16'hFFFF)) begin
        r_wait <= r_wait + 16'd1;
      end
      if (w_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 64, max consecutive cycles the loader may hold a lock.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 c_req / l_req  input  1  core / loader access request, held until granted.
REQ-005 c_we / l_we  input  1  write enable for the request.
REQ-006 c_addr / l_addr  input  32  byte address.
REQ-007 c_wdata / l_wdata  input  32  write data.
REQ-008 l_lock  input  1  loader requests exclusive ownership after its grant.
REQ-009 c_gnt / l_gnt  output  1  request accepted this cycle, combinational.
REQ-010 c_rvalid / l_rvalid  output  1  read data valid for that requester.
REQ-011 c_rdata / l_rdata  output  32  read data, both driven from m_rdata.
REQ-012 m_en, m_we  output  1  memory command valid, write enable.
REQ-013 m_addr, m_wdata  output  32  memory address, write data.
REQ-014 m_ready  input  1  memory accepts a command this cycle.
REQ-015 m_rdata  input  32  memory read data, valid one cycle after an accepted read.
REQ-016 stat_clr  input  1  synchronous clear of the wait counter and timeout flag.
REQ-017 status  output  32  [31] lock-timeout sticky flag, [30] locked, [29:16] zero, [15:0] core-wait count.

Function
REQ-018 A command is issued when m_ready=1 and the selected requester has req=1; m_en and exactly that requester's gnt are asserted in the same cycle.
REQ-019 m_ready=0 -> m_en=0, both gnt=0; requesters hold.
REQ-020 Selection is round-robin on register last_grant: a sole requester wins; on contention the requester not granted last wins; last_grant updates on every grant.
REQ-021 m_we/m_addr/m_wdata mux from the winning requester; when m_en=0 they drive the core's values.
REQ-022 Lock FSM states IDLE, LOCKED; IDLE->LOCKED on l_gnt with l_lock=1.
REQ-023 In LOCKED core is never granted; loader is granted whenever l_req=1 and m_ready=1.
REQ-024 LOCKED->IDLE on l_gnt with l_lock=0, or on any cycle with l_req=0 and l_lock=0.
REQ-025 Lock counter clears on entering LOCKED and increments each LOCKED cycle; at LOCK_MAX-1 the FSM is forced to IDLE next cycle, status[31] set, last_grant=loader so the core wins the next contention.
REQ-026 After a forced exit the loader cannot relock until it has been granted once with l_lock=0 or has dropped l_req.
REQ-027 Read return: on a granted read, register rpend=1 and rsel=requester; next cycle the matching rvalid=1 for exactly one cycle; writes produce no rvalid.
REQ-028 Back-to-back reads to alternating requesters each get their own rvalid in consecutive cycles.
REQ-029 Core-wait count increments each cycle c_req=1 and c_gnt=0, saturating at 16'hFFFF.
REQ-030 stat_clr=1 clears count and status[31] next edge; a same-cycle increment or timeout is lost/overridden by the clear.

Reset
REQ-031 rst=0 immediately forces IDLE, last_grant=loader, lock counter 0, rpend 0, rvalids 0, status 0.
REQ-032 While rst=0, gnt and m_en are forced to 0 regardless of requests.
REQ-033 Reset during an outstanding read discards it; no rvalid follows release.

Verification
REQ-034 After reset, c_req=l_req=1 reads, m_ready=1 -> cycle0 c_gnt, cycle1 l_gnt plus c_rvalid, cycle2 l_rvalid.
REQ-035 Core write 0x100<-0xDEADBEEF with m_ready=0 for 3 cycles -> c_gnt only in 4th cycle, m_we=1, status[15:0]=3.
REQ-036 Loader l_lock=1 for 5 grants while c_req=1 -> core ungranted throughout, status[30]=1; l_lock=0 -> core granted next cycle.
REQ-037 LOCK_MAX=8, loader holds l_lock=1 and l_req=1 -> IDLE after 8 LOCKED cycles, status[31]=1, core granted; stat_clr -> status[31]=0.
REQ-038 rst=0 asserted one cycle after a granted loader read -> l_rvalid stays 0, status=0, after release core wins first contention.
